// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point datapath blocks.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_MULT,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_mul_state_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UDF = 1;
  localparam int FLG_INX = 0;

  // Wide enough for any format this family is instantiated with; callers truncate.
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] q;
    q = FP_MAX_W'(1) << (man_w - 1);
    for (int i = 0; i < exp_w; i++) begin
      q = q | (FP_MAX_W'(1) << (man_w + i));
    end
    return q;
  endfunction

endpackage

// File: rtl/multiplier_fp_param_if.sv
// Start/ready/busy handshake and operand/result bus of the FP multiplier.
interface multiplier_fp_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         ready;
  logic [W-1:0] Y;
  logic [3:0]   flags;

  modport master (output start, A, B, input busy, ready, Y, flags);
  modport slave  (input start, A, B, output busy, ready, Y, flags);
endinterface

// File: rtl/fp_unpack.sv
// Splits an FP word into sign, exponent and significand and classifies it;
// denormals are flushed to zero.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig,
  output fp_class_t            cls
);

  logic [MAN_W-1:0] man;

  assign sign = op[EXP_W+MAN_W];
  assign exp  = op[EXP_W+MAN_W-1:MAN_W];
  assign man  = op[MAN_W-1:0];

  always_comb begin
    cls = FP_NORM;
    if (exp == '0) begin
      cls = FP_ZERO;
    end else if (exp == '1) begin
      cls = (man == '0) ? FP_INF : FP_NAN;
    end
  end

  assign sig = {(cls == FP_NORM), man};

endmodule

// File: rtl/multiplier_fp_param.sv
// Iterative shift-add floating-point multiplier with round-to-nearest-even,
// exception flags and a fast path for special operands.
module multiplier_fp_param
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                  clk,
  input logic                  rst,
  multiplier_fp_param_if.slave bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int P     = MAN_W + 1;
  localparam int CNT_W = $clog2(P + 1);

  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(P - 1);
  localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W + 2)'(fp_bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W + 2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W + 2)'(1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;
  localparam logic [W-1:0]            QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [2*P-1:0]          LOW_MASK = {(2 * P){1'b1}} >> (P + 3);

  function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  function automatic logic [W+3:0] saturate(input logic sgn,
                                            input logic signed [EXP_W+1:0] e,
                                            input logic [MAN_W-1:0] m,
                                            input logic inx);
    logic [3:0]   f;
    logic [W-1:0] y;
    f          = '0;
    f[FLG_INX] = inx;
    if (e >= EXP_MAX) begin
      y          = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      f[FLG_OVF] = 1'b1;
      f[FLG_INX] = 1'b1;
    end else if (e <= EXP_ZERO) begin
      y          = {sgn, {(W - 1){1'b0}}};
      f[FLG_UDF] = 1'b1;
      f[FLG_INX] = 1'b1;
    end else begin
      y = {sgn, e[EXP_W-1:0], m};
    end
    return {f, y};
  endfunction

  fp_mul_state_t state;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]              a_q, b_q;
  logic                      sa, sb;
  logic [EXP_W-1:0]          ea, eb;
  logic [P-1:0]              siga, sigb;
  fp_class_t                 ca, cb;
  logic [2*P-1:0]            mcand, acc, nrm;
  logic [P-1:0]              mplier;
  logic signed [EXP_W+1:0]   exp_s, rexp;
  logic                      sign_n, lost, g, r, s;
  logic [MAN_W-1:0]          man_n;
  logic [MAN_W:0]            msum;
  logic                      spec_hit;
  logic [W-1:0]              spec_y, res_y, round_y;
  logic [3:0]                spec_f, res_f, round_f;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op(a_q), .sign(sa), .exp(ea), .sig(siga), .cls(ca)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op(b_q), .sign(sb), .exp(eb), .sig(sigb), .cls(cb)
  );

  // NaN dominates, then inf*0, then inf, then zero; anything else is a real multiply.
  always_comb begin
    spec_hit = 1'b1;
    spec_y   = '0;
    spec_f   = '0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      spec_y = QNAN;
    end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
      spec_y          = QNAN;
      spec_f[FLG_INV] = 1'b1;
    end else if (ca == FP_INF || cb == FP_INF) begin
      spec_y = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      spec_y = {sa ^ sb, {(W - 1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // The shifted-out bit on a [2,4) product must still feed sticky.
  always_comb begin
    nrm  = acc;
    lost = 1'b0;
    if (acc[2*P-1]) begin
      nrm  = acc >> 1;
      lost = acc[0];
    end
  end

  always_comb begin
    msum = {1'b0, man_n} + {{MAN_W{1'b0}}, rne_up(man_n[0], g, r, s)};
    rexp = exp_s + signed'({{(EXP_W + 1){1'b0}}, msum[MAN_W]});
    {round_f, round_y} = saturate(sign_n, rexp, msum[MAN_W-1:0], g | r | s);
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          a_q <= bus.A;
          b_q <= bus.B;
        end
      end
      ST_UNPACK: begin
        mcand  <= {{P{1'b0}}, siga};
        mplier <= sigb;
        acc    <= '0;
        exp_s  <= signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS;
        sign_n <= sa ^ sb;
        res_y  <= spec_y;
        res_f  <= spec_f;
      end
      ST_MULT: begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      ST_NORM: begin
        man_n <= nrm[2*P-3:P-1];
        g     <= nrm[P-2];
        r     <= nrm[P-3];
        s     <= lost | (|(nrm & LOW_MASK));
        if (acc[2*P-1]) exp_s <= exp_s + EXP_ONE;
      end
      default: ;
    endcase
  end

  // Control FSM; ROUND publishes directly, specials publish on their first DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
      bus.Y     <= '0;
      bus.flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state    <= ST_UNPACK;
            bus.busy <= 1'b1;
          end
        end
        ST_UNPACK: begin
          cnt   <= '0;
          state <= spec_hit ? ST_DONE : ST_MULT;
        end
        ST_MULT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_NORM;
        end
        ST_NORM: state <= ST_ROUND;
        ST_ROUND: begin
          bus.Y     <= round_y;
          bus.flags <= round_f;
          bus.ready <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.ready) begin
            bus.Y     <= res_y;
            bus.flags <= res_f;
            bus.ready <= 1'b1;
          end else begin
            bus.ready <= 1'b0;
            bus.busy  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multiplier_fp_param.md
Name: multiplier_fp_param

Overview:
Parametrised IEEE-754-style floating-point multiplier and the successor of the fixed single-precision multiplier_fp. Exponent and mantissa widths are set by parameter. The block uses an iterative shift-add significand multiplier and a start/ready/busy handshake. Unlike its predecessor, it adds round-to-nearest-even, exception flags, a fast path for special operands, and an asynchronous reset. It sits in the FP datapath beside the adder and divider blocks.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored mantissa field width (>=2); significand width P = MAN_W+1
W, 1+EXP_W+MAN_W, derived total word width (localparam, not overridable)

Ports:
clk    in   1     rising-edge clock
rst    in   1     asynchronous active-high reset
start  in   1     request; sampled only in IDLE
A      in   W     operand A; captured on the accepted start edge
B      in   W     operand B; captured on the accepted start edge
busy   out  1     high in every state except IDLE
ready  out  1     one-cycle pulse; Y and flags are valid in this cycle
Y      out  W     product; holds its value until the next DONE
flags  out  4     {invalid, overflow, underflow, inexact}; holds with Y

Behaviour:
- Reset: while rst is high, or asynchronously on assertion, the state is IDLE and busy=0, ready=0, Y=0, flags=0. Reset mid-operation aborts the operation; no ready pulse is produced.
- States: IDLE, UNPACK, MULT, NORM, ROUND, DONE.
- IDLE:
  - start=1 captures A and B and moves to UNPACK.
  - start is ignored in all other states, including DONE.
- UNPACK:
  - Classify each operand as zero, normal, inf or nan.
  - Denormal inputs (exp=0) are flushed to signed zero.
  - Special cases go directly to DONE.
  - Otherwise load the significands {1,man}, set exponent sum = eA+eB-bias (bias = 2^(EXP_W-1)-1, computed at EXP_W+2 bits signed), set sign = sA^sB, clear the 2P-bit product, and go to MULT.
- MULT:
  - One multiplier bit per cycle, LSB first, for exactly P cycles. An internal counter of width clog2(P+1) controls the count.
  - The product is held in a 2P-bit accumulator.
- NORM:
  - If product bit 2P-1 is set: shift right 1 and increment the exponent.
  - Form guard bit, round bit and sticky bit (OR of all remaining bits).
- ROUND:
  - Round to nearest, ties to even.
  - A mantissa carry-out increments the exponent.
  - inexact = G|R|S.
  - Biased exponent >= 2^EXP_W-1: result is ±inf, overflow=1, inexact=1.
  - Biased exponent <= 0: result is ±0 (flush to zero), underflow=1, inexact=1.
- DONE: register Y and flags, assert ready for one cycle, return to IDLE.
- Latency: start sampled at edge k.
  - Normal operands: ready is high in the cycle after edge k+P+3. Single precision takes 27 cycles; half precision takes 14.
  - Special operands: ready is high in the cycle after edge k+2.
- Special rules:
  - Any NaN input gives canonical qNaN (sign 0, exp all ones, mantissa MSB 1, rest 0), with flags=0.
  - inf×0 gives canonical qNaN with invalid=1.
  - inf×(normal or inf) gives signed inf with flags=0.
  - 0×(normal or 0) gives signed zero with flags=0.
- A back-to-back start in the cycle immediately after ready is accepted.

Decomposition:
- Package fp_pkg holds:
  - state enum fp_mul_state_t
  - operand class enum fp_class_t {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - flag index constants FLG_INV, FLG_OVF, FLG_UDF, FLG_INX
  - functions fp_bias(EXP_W) and fp_qnan(EXP_W, MAN_W)
- One combinational sub-module, fp_unpack, instantiated twice. It splits an operand into sign, exponent and significand and produces its fp_class_t.

Test Plan:
- Default parameters, A=0x40C00000 (6.0), B=0x40200000 (2.5) -> Y=0x41700000, flags=0, ready exactly 27 cycles after start. Repeat with A=0xC0A00000, B=0xC0400000 -> Y=0x41700000.
- A=0x3F800001, B=0x3F800001 -> Y=0x3F800002, flags=0001 (RNE rounds down, inexact set).
- Specials, each with ready 2 cycles after start:
  - A=0x7F800000, B=0x1EC22880 -> Y=0x7F800000, flags=0.
  - A=0x7F800001, B=0x1EC22880 -> Y=0x7FC00000, flags=0.
  - A=0x7F800000, B=0x00000000 -> Y=0x7FC00000, flags=1000.
- Range limits:
  - A=0x7F000000, B=0x7F000000 -> Y=0x7F800000, flags=0101.
  - A=0x00800000, B=0x3F000000 -> Y=0x00000000, flags=0011.
- EXP_W=5, MAN_W=10, A=0x4000 (2.0), B=0x4200 (3.0) -> Y=0x4600, ready 14 cycles after start.
- Protocol and reset:
  - start pulsed while busy -> ignored; the first result is unchanged.
  - rst asserted mid-MULT -> busy, ready, Y and flags go to 0 immediately with no ready pulse; a new start after release completes normally.
